uart_port_scheduler: RTL and testbench

UART_PORT_SCHEDULER -- requirements
Module: uart_port_scheduler

---
 rtl/uart_port_scheduler.sv | 85 ++++++++
 tb/tb_uart_port_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_scheduler.sv
// uart_port_scheduler: round-robin TX requester arbiter (req/req_data/gnt -> write_data/bus_data_in, paced by tx_full) plus RX fetcher (rx_empty/read_data/bus_data_out -> rx_valid/rx_data/rx_ready) with saturating tx_count/rx_count
module uart_port_scheduler #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic                           tx_full,
  output logic                           write_data,
  output logic [DATA_SIZE-1:0]           bus_data_in,
  input  logic                           rx_empty,
  output logic                           read_data,
  input  logic [DATA_SIZE-1:0]           bus_data_out,
  output logic                           rx_valid,
  output logic [DATA_SIZE-1:0]           rx_data,
  input  logic                           rx_ready,
  output logic [CNT_W-1:0]               tx_count,
  output logic [CNT_W-1:0]               rx_count
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {TX_IDLE, TX_GAP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_READ, RX_CAP, RX_HOLD} rx_state_t;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic [PW-1:0] rr_ptr, winner, idx;
  logic found;
  logic [DATA_SIZE-1:0] rx_q;
  always_comb begin
    winner = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    write_data = !reset && tx_state == TX_IDLE && found && !tx_full;
    tx_next = write_data ? TX_GAP : TX_IDLE;
    gnt = '0;
    bus_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (write_data && winner == PW'(i)) begin
        gnt[i] = 1'b1;
        bus_data_in = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
  end
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: rx_next = rx_empty ? RX_IDLE : RX_READ;
      RX_READ: rx_next = RX_CAP;
      RX_CAP:  rx_next = rx_ready ? RX_IDLE : RX_HOLD;
      RX_HOLD: rx_next = rx_ready ? RX_IDLE : RX_HOLD;
      default: rx_next = RX_IDLE;
    endcase
  end
  assign read_data = rx_state == RX_READ;
  assign rx_valid = rx_state == RX_CAP || rx_state == RX_HOLD;
  // bus_data_out is valid during RX_CAP, so it is presented directly then and held from rx_q afterwards
  assign rx_data = rx_state == RX_CAP ? bus_data_out : rx_state == RX_HOLD ? rx_q : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
      rr_ptr <= '0;
      rx_q <= '0;
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      if (write_data) rr_ptr <= winner == PW'(NUM_REQ - 1) ? '0 : winner + 1'b1;
      if (rx_state == RX_CAP) rx_q <= bus_data_out;
      if (write_data && tx_count != '1) tx_count <= tx_count + 1'b1;
      if (rx_valid && rx_ready && rx_count != '1) rx_count <= rx_count + 1'b1;
    end
endmodule

// File: tb/tb_uart_port_scheduler.sv
// tb_uart_port_scheduler: directed and randomized loopback checks of uart_port_scheduler against a queue-based UART/requester model
module tb_uart_port_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic tx_full = 0, rx_empty = 1, rx_ready = 0;
  logic [W-1:0] bus_data_out = '0;
  logic [N-1:0] gnt, s_gnt;
  logic write_data, s_wr, read_data, s_rd, rx_valid, s_rv;
  logic [W-1:0] bus_data_in, s_bus, rx_data, s_rdata;
  logic [15:0] tx_count, rx_count;
  logic [2:0] s_txc, s_rxc;
  int n_tests = 0, n_fail = 0;
  bit pend [N];
  logic [W-1:0] pdata [N];
  logic [W-1:0] wq[$], eq[$], rcv[$];
  int ptr = 0, nw = 0, nr = 0;
  bit gap = 0, rd_prev = 0, hold_prev = 0;
  logic [W-1:0] rd_byte = '0, last_data = '0;

  always #5 clk = ~clk;

  uart_port_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_full(tx_full), .write_data(write_data), .bus_data_in(bus_data_in),
    .rx_empty(rx_empty), .read_data(read_data), .bus_data_out(bus_data_out),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  uart_port_scheduler #(.CNT_W(3)) sat (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(s_gnt),
    .tx_full(tx_full), .write_data(s_wr), .bus_data_in(s_bus),
    .rx_empty(rx_empty), .read_data(s_rd), .bus_data_out(bus_data_out),
    .rx_valid(s_rv), .rx_data(s_rdata), .rx_ready(rx_ready),
    .tx_count(s_txc), .rx_count(s_rxc)
  );

  task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string t);
    ck({t, "_gnt"}, gnt, 0);
    ck({t, "_wr"}, write_data, 0);
    ck({t, "_bus"}, bus_data_in, 0);
    ck({t, "_rd"}, read_data, 0);
    ck({t, "_rv"}, rx_valid, 0);
    ck({t, "_rdata"}, rx_data, 0);
    ck({t, "_txc"}, tx_count, 0);
    ck({t, "_rxc"}, rx_count, 0);
    ck({t, "_s_txc"}, s_txc, 0);
  endtask

  task automatic mstep(input bit rnd);
    int w;
    nxt();
    for (int i = 0; i < N; i++) begin
      if (rnd && !pend[i] && $urandom_range(2) == 0) begin
        pend[i] = 1;
        pdata[i] = W'($urandom);
      end else if (rnd && pend[i] && $urandom_range(19) == 0) pend[i] = 0;
      req[i] = pend[i];
      req_data[i*W +: W] = pdata[i];
    end
    tx_full = wq.size() >= 3;
    rx_empty = wq.size() == 0;
    bus_data_out = rd_prev ? rd_byte : W'($urandom);
    rx_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
    #1;
    ck("m_txc", tx_count, nw > 65535 ? 65535 : nw);
    ck("m_rxc", rx_count, nr > 65535 ? 65535 : nr);
    ck("m_s_txc", s_txc, nw > 7 ? 7 : nw);
    ck("m_s_rxc", s_rxc, nr > 7 ? 7 : nr);
    w = -1;
    if (!gap && !tx_full)
      for (int k = 0; k < N; k++)
        if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
    ck("m_wr", write_data, w >= 0);
    ck("m_gnt", gnt, w >= 0 ? 1 << w : 0);
    ck("m_bus", bus_data_in, w >= 0 ? pdata[w] : 0);
    ck("m_rd_while_valid", read_data && rx_valid, 0);
    if (read_data) begin
      ck("m_rd_empty", wq.size() > 0, 1);
      if (wq.size() > 0) rd_byte = wq.pop_front();
    end
    rd_prev = read_data;
    if (hold_prev) ck("m_rx_stable", {rx_valid, rx_data}, {1'b1, last_data});
    if (rx_valid && rx_ready) begin
      ck("m_rx_order", rx_data, eq.size() > 0 ? eq[0] : 8'hxx);
      if (eq.size() > 0) void'(eq.pop_front());
      rcv.push_back(rx_data);
      nr++;
    end
    hold_prev = rx_valid && !rx_ready;
    last_data = rx_data;
    if (w >= 0) begin
      wq.push_back(pdata[w]);
      eq.push_back(pdata[w]);
      pend[w] = 0;
      ptr = (w + 1) % N;
      nw++;
    end
    gap = w >= 0;
  endtask

  initial begin
    nxt();
    nxt();
    #1;
    chk_idle("rst");
    // round-robin over four held requests
    nxt();
    reset = 0;
    req = '1;
    req_data = 32'hA3A2A1A0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        nxt();
        if (c % 2 == 1) req[(c - 1) / 2] = 0;
      end
      #1;
      ck("t35_wr", write_data, c % 2 == 0);
      ck("t35_gnt", gnt, c % 2 == 0 ? 1 << (c / 2) : 0);
      ck("t35_bus", bus_data_in, c % 2 == 0 ? 8'hA0 + c / 2 : 0);
    end
    nxt();
    #1;
    ck("t35_txc", tx_count, 4);
    ck("t35_s_txc", s_txc, 4);
    // tx_full blocks writes and holds the pointer
    for (int c = 0; c < 10; c++) begin
      nxt();
      req = 4'b0101;
      tx_full = 1;
      #1;
      ck("t36_full_wr", write_data, 0);
      ck("t36_full_gnt", gnt, 0);
    end
    nxt();
    tx_full = 0;
    #1;
    ck("t36_gnt0", gnt, 4'b0001);
    ck("t36_bus0", bus_data_in, 8'hA0);
    nxt();
    req = 4'b0100;
    #1;
    ck("t36_gap", {gnt, write_data}, 0);
    nxt();
    #1;
    ck("t36_gnt2", gnt, 4'b0100);
    ck("t36_bus2", bus_data_in, 8'hA2);
    nxt();
    req = 0;
    #1;
    ck("t36_txc", tx_count, 6);
    ck("t36_s_txc", s_txc, 6);
    // RX fetch with back-pressure
    nxt();
    rx_empty = 0;
    bus_data_out = 8'h5C;
    rx_ready = 0;
    #1;
    ck("t37_c0", {read_data, rx_valid}, 0);
    nxt();
    #1;
    ck("t37_c1_rd", read_data, 1);
    ck("t37_c1_rv", rx_valid, 0);
    nxt();
    #1;
    ck("t37_c2_rd", read_data, 0);
    ck("t37_c2_rv", rx_valid, 1);
    ck("t37_c2_data", rx_data, 8'h5C);
    for (int c = 3; c < 7; c++) begin
      nxt();
      bus_data_out = 8'hFF;
      #1;
      ck("t37_hold_rd", read_data, 0);
      ck("t37_hold", {rx_valid, rx_data}, {1'b1, 8'h5C});
    end
    nxt();
    rx_ready = 1;
    #1;
    ck("t37_acc", {rx_valid, rx_data}, {1'b1, 8'h5C});
    nxt();
    #1;
    ck("t37_after_rv", rx_valid, 0);
    ck("t37_rxc", rx_count, 1);
    nxt();
    rx_empty = 1;
    #1;
    ck("t37_reread", read_data, 1);
    nxt();
    #1;
    ck("t37_cap2", {rx_valid, rx_data}, {1'b1, 8'hFF});
    nxt();
    rx_ready = 0;
    #1;
    ck("t37_rxc2", rx_count, 2);
    ck("t37_s_rxc2", s_rxc, 2);
    // reset while RX_HOLD and TX_GAP
    nxt();
    rx_empty = 0;
    bus_data_out = 8'h33;
    nxt();
    rx_empty = 1;
    nxt();
    nxt();
    req = 4'b0010;
    #1;
    ck("t39_wr", {write_data, gnt, bus_data_in}, {1'b1, 4'b0010, 8'hA1});
    ck("t39_hold", {rx_valid, rx_data}, {1'b1, 8'h33});
    nxt();
    req = 0;
    #1;
    ck("t39_gap", {write_data, gnt}, 0);
    ck("t39_hold2", rx_valid, 1);
    reset = 1;
    req = 4'b1000;
    #1;
    chk_idle("t39_rst");
    nxt();
    #1;
    ck("t39_rst_held", {gnt, write_data}, 0);
    nxt();
    reset = 0;
    #1;
    ck("t39_first_gnt", gnt, 4'b1000);
    ck("t39_first_bus", {write_data, bus_data_in}, {1'b1, 8'hA3});
    nxt();
    reset = 1;
    req = 0;
    rx_empty = 1;
    nxt();
    reset = 0;
    // two-byte loopback through requester 0
    pend[0] = 1;
    pdata[0] = 8'h24;
    for (int c = 0; c < 40 && rcv.size() < 2; c++) begin
      mstep(0);
      if (!pend[0] && pdata[0] == 8'h24) begin
        pend[0] = 1;
        pdata[0] = 8'h81;
      end
    end
    ck("t40_n", rcv.size(), 2);
    if (rcv.size() == 2) begin
      ck("t40_b0", rcv[0], 8'h24);
      ck("t40_b1", rcv[1], 8'h81);
    end
    for (int c = 0; c < 800; c++) mstep(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
